// File: rtl/dsm_ctrl_pkg.sv
// rtl/dsm_ctrl_pkg.sv - shared types and widths for the DSM NCO sweep controller
package dsm_ctrl_pkg;

  localparam int STEP_WIDTH  = 32;
  localparam int DWELL_WIDTH = 16;
  localparam int COUNT_WIDTH = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  typedef struct packed {
    logic [STEP_WIDTH-1:0]  start;
    logic [STEP_WIDTH-1:0]  stop;
    logic [STEP_WIDTH-1:0]  delta;
    logic [DWELL_WIDTH-1:0] dwell;
    logic                   continuous;
  } sweep_cfg_t;

  // A dwell of 0 is held like a dwell of 1, so the reload never underflows.
  function automatic logic [DWELL_WIDTH-1:0] dwell_reload(input logic [DWELL_WIDTH-1:0] dwell);
    return (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);
  endfunction

endpackage

// File: rtl/dsm_step_next.sv
// rtl/dsm_step_next.sv - next sweep point, clamped to stop and saturated on carry
module dsm_step_next #(
  parameter int STEP_WIDTH = 32
) (
  input  logic [STEP_WIDTH-1:0] p,
  input  logic [STEP_WIDTH-1:0] delta,
  input  logic [STEP_WIDTH-1:0] stop,
  output logic [STEP_WIDTH-1:0] next_p,
  output logic                  last
);

  logic [STEP_WIDTH:0] sum;

  assign sum    = {1'b0, p} + {1'b0, delta};
  assign next_p = (sum[STEP_WIDTH] || (sum[STEP_WIDTH-1:0] >= stop)) ? stop : sum[STEP_WIDTH-1:0];
  assign last   = (p >= stop) || (delta == '0);

endmodule

// File: rtl/dsm_sweep_ctrl.sv
// rtl/dsm_sweep_ctrl.sv - linear NCO step sweep sequencer with per-point dwell
module dsm_sweep_ctrl #(
  parameter int STEP_WIDTH  = 32,
  parameter int DWELL_WIDTH = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   arst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [STEP_WIDTH-1:0]  cfg_start_step,
  input  logic [STEP_WIDTH-1:0]  cfg_stop_step,
  input  logic [STEP_WIDTH-1:0]  cfg_delta,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_continuous,
  output logic [STEP_WIDTH-1:0]  nco_step,
  output logic                   nco_step_enable,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] sweep_count
);

  import dsm_ctrl_pkg::*;

  state_t                 state_q, state_d;
  sweep_cfg_t             cfg_q, cfg_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [STEP_WIDTH-1:0]  step_d;
  logic                   enable_d, busy_d, done_d;
  logic [COUNT_WIDTH-1:0] count_d;
  logic [STEP_WIDTH-1:0]  next_p;
  logic                   last;

  // nco_step always holds the point being dwelt on, so last/next derive from it.
  dsm_step_next #(.STEP_WIDTH(STEP_WIDTH)) u_step_next (
    .p      (nco_step),
    .delta  (cfg_q.delta),
    .stop   (cfg_q.stop),
    .next_p (next_p),
    .last   (last)
  );

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q         <= IDLE;
      cfg_q           <= '0;
      dwell_q         <= '0;
      nco_step        <= '0;
      nco_step_enable <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      sweep_count     <= '0;
    end else begin
      state_q         <= state_d;
      cfg_q           <= cfg_d;
      dwell_q         <= dwell_d;
      nco_step        <= step_d;
      nco_step_enable <= enable_d;
      busy            <= busy_d;
      done            <= done_d;
      sweep_count     <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    dwell_d  = dwell_q;
    step_d   = nco_step;
    enable_d = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;
    count_d  = sweep_count;
    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cfg_d    = '{start: cfg_start_step, stop: cfg_stop_step, delta: cfg_delta,
                         dwell: cfg_dwell, continuous: cfg_continuous};
            step_d   = cfg_start_step;
            enable_d = 1'b1;
            busy_d   = 1'b1;
            dwell_d  = dwell_reload(cfg_dwell);
            state_d  = DWELL;
          end
        end
        DWELL: begin
          if (dwell_q != '0) begin
            dwell_d = dwell_q - DWELL_WIDTH'(1);
          end else if (!last) begin
            step_d   = next_p;
            enable_d = 1'b1;
            dwell_d  = dwell_reload(cfg_q.dwell);
          end else if (cfg_q.continuous) begin
            count_d  = sweep_count + COUNT_WIDTH'(1);
            step_d   = cfg_q.start;
            enable_d = 1'b1;
            dwell_d  = dwell_reload(cfg_q.dwell);
          end else begin
            count_d = sweep_count + COUNT_WIDTH'(1);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsm_sweep_ctrl.sv
// tb/tb_dsm_sweep_ctrl.sv - directed self-checking bench for dsm_sweep_ctrl
module tb_dsm_sweep_ctrl;

  logic        aclk = 1'b0;
  logic        arst_n;
  logic        start, abort;
  logic [31:0] cfg_start_step, cfg_stop_step, cfg_delta;
  logic [15:0] cfg_dwell;
  logic        cfg_continuous;
  logic [31:0] nco_step;
  logic        nco_step_enable, busy, done;
  logic [15:0] sweep_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pts [0:3];

  dsm_sweep_ctrl dut (
    .aclk            (aclk),
    .arst_n          (arst_n),
    .start           (start),
    .abort           (abort),
    .cfg_start_step  (cfg_start_step),
    .cfg_stop_step   (cfg_stop_step),
    .cfg_delta       (cfg_delta),
    .cfg_dwell       (cfg_dwell),
    .cfg_continuous  (cfg_continuous),
    .nco_step        (nco_step),
    .nco_step_enable (nco_step_enable),
    .busy            (busy),
    .done            (done),
    .sweep_count     (sweep_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch at the current negedge; a second start mid-sweep must be ignored.
  task automatic run_oneshot(input logic [31:0] s, input logic [31:0] st, input logic [31:0] d,
                             input logic [15:0] dw, input int n, input logic [15:0] exp_count);
    int dd, total;
    cfg_start_step = s; cfg_stop_step = st; cfg_delta = d; cfg_dwell = dw; cfg_continuous = 1'b0;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    cfg_start_step = $urandom; cfg_stop_step = $urandom; cfg_delta = $urandom;
    cfg_dwell = 16'($urandom_range(0, 9)); cfg_continuous = 1'b1;
    dd = (dw == 0) ? 1 : int'(dw);
    total = n * dd;
    for (int c = 1; c <= total; c++) begin
      chk("enable", 64'(nco_step_enable), 64'(((c - 1) % dd) == 0));
      if (((c - 1) % dd) == 0) chk("point", 64'(nco_step), 64'(exp_pts[(c - 1) / dd]));
      chk("busy", 64'(busy), 64'd1);
      chk("done_early", 64'(done), 64'd0);
      start = (c == 2) && (total > 2);
      @(negedge aclk);
    end
    start = 1'b0;
    chk("done", 64'(done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("enable_end", 64'(nco_step_enable), 64'd0);
    chk("hold_end", 64'(nco_step), 64'(exp_pts[n - 1]));
    chk("count", 64'(sweep_count), 64'(exp_count));
  endtask

  initial begin
    arst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_start_step = '0; cfg_stop_step = '0; cfg_delta = '0; cfg_dwell = '0; cfg_continuous = 1'b0;
    #12;
    chk("rst_step", 64'(nco_step), 64'd0);
    chk("rst_enable", 64'(nco_step_enable), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(sweep_count), 64'd0);
    @(negedge aclk);
    arst_n = 1'b1;
    @(negedge aclk);
    chk("idle_busy", 64'(busy), 64'd0);

    exp_pts = '{32'd100, 32'd110, 32'd120, 32'd130};
    run_oneshot(32'd100, 32'd130, 32'd10, 16'd4, 4, 16'd1);
    exp_pts = '{32'd100, 32'd110, 32'd120, 32'd125};
    run_oneshot(32'd100, 32'd125, 32'd10, 16'd2, 4, 16'd2);
    exp_pts = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0};
    run_oneshot(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 2, 16'd3);
    exp_pts = '{32'd50, 32'd0, 32'd0, 32'd0};
    run_oneshot(32'd50, 32'd20, 32'd5, 16'd0, 1, 16'd4);
    exp_pts = '{32'd7, 32'd0, 32'd0, 32'd0};
    run_oneshot(32'd7, 32'd100, 32'd0, 16'd3, 1, 16'd5);

    // Continuous 0,10,20 with dwell 3; wrap at cycle 10, abort sampled at end of cycle 14.
    @(negedge aclk);
    exp_pts = '{32'd0, 32'd10, 32'd20, 32'd0};
    cfg_start_step = 32'd0; cfg_stop_step = 32'd20; cfg_delta = 32'd10;
    cfg_dwell = 16'd3; cfg_continuous = 1'b1;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      chk("c_enable", 64'(nco_step_enable), 64'(((c - 1) % 3) == 0));
      if (((c - 1) % 3) == 0) chk("c_point", 64'(nco_step), 64'(exp_pts[((c - 1) / 3) % 3]));
      chk("c_busy", 64'(busy), 64'd1);
      chk("c_done", 64'(done), 64'd0);
      chk("c_count", 64'(sweep_count), (c >= 10) ? 64'd6 : 64'd5);
      abort = (c == 14);
      @(negedge aclk);
    end
    abort = 1'b0;
    for (int c = 15; c <= 20; c++) begin
      chk("a_busy", 64'(busy), 64'd0);
      chk("a_enable", 64'(nco_step_enable), 64'd0);
      chk("a_done", 64'(done), 64'd0);
      chk("a_hold", 64'(nco_step), 64'd10);
      chk("a_count", 64'(sweep_count), 64'd6);
      @(negedge aclk);
    end

    // Start together with abort in idle must not launch.
    cfg_start_step = 32'd300; cfg_stop_step = 32'd400; cfg_delta = 32'd1; cfg_dwell = 16'd2;
    cfg_continuous = 1'b0;
    start = 1'b1; abort = 1'b1;
    @(negedge aclk);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 64'(busy), 64'd0);
    chk("sa_enable", 64'(nco_step_enable), 64'd0);
    chk("sa_hold", 64'(nco_step), 64'd10);
    @(negedge aclk);
    chk("sa_busy2", 64'(busy), 64'd0);

    // Asynchronous reset mid-sweep.
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    chk("r_point", 64'(nco_step), 64'd300);
    @(negedge aclk);
    #1 arst_n = 1'b0;
    #1;
    chk("ar_step", 64'(nco_step), 64'd0);
    chk("ar_enable", 64'(nco_step_enable), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_done", 64'(done), 64'd0);
    chk("ar_count", 64'(sweep_count), 64'd0);
    @(negedge aclk);
    arst_n = 1'b1;
    @(negedge aclk);
    chk("ar_idle_busy", 64'(busy), 64'd0);
    chk("ar_idle_enable", 64'(nco_step_enable), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
